// File: rtl/vga_timing_if.sv
// vga_timing_if
//   Raster bus between the timing generator and the sprite mappers.
//   master : driven by vga_timing_gen
//   slave  : consumed by mappers / video output
//   Signals:
//     DrawX, DrawY          current pixel column / line
//     hs, vs                active-low syncs aligned to DrawX/DrawY
//     blank                 1 = visible pixel
//     frame_start           one-cycle pulse at DrawX==0 && DrawY==0
//     hs_d, vs_d, blank_d   hs/vs/blank delayed to match mapper colour latency
//     frame_count           8-bit frame counter (only with VGA_FRAME_COUNT_EN)
interface vga_timing_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       frame_start;
  logic       hs_d;
  logic       vs_d;
  logic       blank_d;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count;
`endif

  modport master (
`ifdef VGA_FRAME_COUNT_EN
    output frame_count,
`endif
    output DrawX, DrawY, hs, vs, blank, frame_start, hs_d, vs_d, blank_d
  );

  modport slave (
`ifdef VGA_FRAME_COUNT_EN
    input frame_count,
`endif
    input DrawX, DrawY, hs, vs, blank, frame_start, hs_d, vs_d, blank_d
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing source (default 640x480@60, 25 MHz pixel clock).
//   Produces the pixel/line counters, active-low syncs, the visible-region
//   flag and a frame-start pulse, plus copies of hs/vs/blank delayed by
//   PIPE_DELAY cycles so the syncs line up with registered mapper colour.
//   Ports:
//     vga_clk  in   pixel clock, rising edge
//     reset_n  in   asynchronous active-low reset
//     vga      vga_timing_if.master (DrawX, DrawY, hs, vs, blank,
//              frame_start, hs_d, vs_d, blank_d[, frame_count])
//   Optional feature macro: VGA_FRAME_COUNT_EN adds the 8-bit frame_count
//   output, incremented on every cycle in which frame_start is high.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic         vga_clk,
  input  logic         reset_n,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG  = H_VISIBLE + H_FRONT;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_VISIBLE + V_FRONT;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: line or frame total exceeds 10-bit counter range");
  end

  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 0..7");
  end

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank;
  logic       r_frame_start;

  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_eol;
  logic       w_eof;
  logic       w_hs_nxt;
  logic       w_vs_nxt;
  logic       w_blank_nxt;
  logic       w_frame_start_nxt;

  // Decode is done on the next counter values so the registered flags are
  // valid in the same cycle as the DrawX/DrawY they describe.
  always_comb begin
    w_eol   = (r_x == H_LAST);
    w_eof   = w_eol && (r_y == V_LAST);
    w_x_nxt = w_eol ? 10'd0 : r_x + 10'd1;
    w_y_nxt = r_y;
    if (w_eof) begin
      w_y_nxt = 10'd0;
    end else if (w_eol) begin
      w_y_nxt = r_y + 10'd1;
    end
    w_hs_nxt          = !((int'(w_x_nxt) >= HS_BEG) && (int'(w_x_nxt) < HS_END));
    w_vs_nxt          = !((int'(w_y_nxt) >= VS_BEG) && (int'(w_y_nxt) < VS_END));
    w_blank_nxt       = (int'(w_x_nxt) < H_VISIBLE) && (int'(w_y_nxt) < V_VISIBLE);
    w_frame_start_nxt = (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hs          <= w_hs_nxt;
      r_vs          <= w_vs_nxt;
      r_blank       <= w_blank_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign vga.DrawX       = r_x;
  assign vga.DrawY       = r_y;
  assign vga.hs          = r_hs;
  assign vga.vs          = r_vs;
  assign vga.blank       = r_blank;
  assign vga.frame_start = r_frame_start;

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign vga.hs_d    = r_hs;
    assign vga.vs_d    = r_vs;
    assign vga.blank_d = r_blank;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] r_hs_pipe;
    logic [PIPE_DELAY-1:0] r_vs_pipe;
    logic [PIPE_DELAY-1:0] r_blank_pipe;

    // Bit 0 is the newest stage; truncating the concatenation drops the
    // oldest bit, which works for any depth including 1.
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_hs_pipe    <= '1;
        r_vs_pipe    <= '1;
        r_blank_pipe <= '0;
      end else begin
        r_hs_pipe    <= PIPE_DELAY'({r_hs_pipe, r_hs});
        r_vs_pipe    <= PIPE_DELAY'({r_vs_pipe, r_vs});
        r_blank_pipe <= PIPE_DELAY'({r_blank_pipe, r_blank});
      end
    end

    assign vga.hs_d    = r_hs_pipe[PIPE_DELAY-1];
    assign vga.vs_d    = r_vs_pipe[PIPE_DELAY-1];
    assign vga.blank_d = r_blank_pipe[PIPE_DELAY-1];
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frame_count;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_count <= '0;
    end else if (r_frame_start) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign vga.frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and
// mid-line reset, and a shrunk-timing instance (12x8 raster, 3-stage delay)
// for frame-level behaviour, checked cycle by cycle against a closed-form
// model of the raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_big_n   = 1'b0;
  logic rst_small_n = 1'b0;

  int total = 0;
  int bad   = 0;

  vga_timing_if if_big();
  vga_timing_if if_small();

  localparam int S_HV = 8, S_HF = 1, S_HS = 2, S_HB = 1;
  localparam int S_VV = 4, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_D  = 3;
  localparam int SH   = S_HV + S_HF + S_HS + S_HB;
  localparam int SV   = S_VV + S_VF + S_VS + S_VB;
  localparam int SF   = SH * SV;

  vga_timing_gen u_big (
    .vga_clk (clk),
    .reset_n (rst_big_n),
    .vga     (if_big)
  );

  vga_timing_gen #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .PIPE_DELAY(S_D)
  ) u_small (
    .vga_clk (clk),
    .reset_n (rst_small_n),
    .vga     (if_small)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard for the small instance ----------------
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic       hs_d;
    logic       vs_d;
    logic       blank_d;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] fc;
`endif
  } obs_t;

  obs_t sbq[$];
  int   n_small = 0;
  bit   sb_run  = 0;

  // {hs, vs, blank} of the raster state n edges after reset release;
  // n <= 0 is the reset state.
  function automatic logic [2:0] sync_at(input int n);
    int x, y;
    if (n <= 0) return 3'b110;
    x = n % SH;
    y = (n / SH) % SV;
    return {!(x >= S_HV + S_HF && x < S_HV + S_HF + S_HS),
            !(y >= S_VV + S_VF && y < S_VV + S_VF + S_VS),
            (x < S_HV) && (y < S_VV)};
  endfunction

  function automatic obs_t model(input int n);
    obs_t o;
    logic [2:0] s, sd;
    s  = sync_at(n);
    sd = sync_at(n - S_D);
    o.x       = (n <= 0) ? 10'd0 : 10'(n % SH);
    o.y       = (n <= 0) ? 10'd0 : 10'((n / SH) % SV);
    o.hs      = s[2];
    o.vs      = s[1];
    o.blank   = s[0];
    o.fs      = (n > 0) && (n % SF == 0);
    o.hs_d    = sd[2];
    o.vs_d    = sd[1];
    o.blank_d = sd[0];
`ifdef VGA_FRAME_COUNT_EN
    o.fc      = (n <= 0) ? 8'd0 : 8'((n - 1) / SF);
`endif
    return o;
  endfunction

  always @(posedge clk) begin
    if (sb_run) begin
      n_small = n_small + 1;
      sbq.push_back(model(n_small));
    end
  end

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      obs_t e, a;
      e = sbq.pop_front();
      a.x       = if_small.DrawX;
      a.y       = if_small.DrawY;
      a.hs      = if_small.hs;
      a.vs      = if_small.vs;
      a.blank   = if_small.blank;
      a.fs      = if_small.frame_start;
      a.hs_d    = if_small.hs_d;
      a.vs_d    = if_small.vs_d;
      a.blank_d = if_small.blank_d;
`ifdef VGA_FRAME_COUNT_EN
      a.fc      = if_small.frame_count;
`endif
      check($sformatf("sb n=%0d", n_small), a, e);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic       hs_d;
    logic       blank_d;
  } vec_t;

  vec_t vecs[16];

`ifdef VGA_FRAME_COUNT_EN
  localparam int NPULSE = 257;
`else
  localparam int NPULSE = 4;
`endif

  initial begin
    int cur, hs_low, bl_cnt, vs_low, fs_cnt, gap, guard, last_pulse;

    // cyc = edges since reset release; hs_d/blank_d follow hs/blank two cycles late
    vecs[0]  = '{1,   10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3,   10'd3,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{639, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{640, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{641, 10'd641, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{642, 10'd642, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{655, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{656, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{657, 10'd657, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{658, 10'd658, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{751, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{752, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{754, 10'd754, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{799, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{800, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{802, 10'd2,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // reset held 10 cycles
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst.x",       if_big.DrawX,         0);
    check("rst.y",       if_big.DrawY,         0);
    check("rst.hs",      if_big.hs,            1);
    check("rst.vs",      if_big.vs,            1);
    check("rst.blank",   if_big.blank,         0);
    check("rst.fs",      if_big.frame_start,   0);
    check("rst.hs_d",    if_big.hs_d,          1);
    check("rst.vs_d",    if_big.vs_d,          1);
    check("rst.blank_d", if_big.blank_d,       0);
    check("rst.s_hs_d",  if_small.hs_d,        1);
    check("rst.s_blank", if_small.blank,       0);

    // first line, table driven
    rst_big_n = 1'b1;
    cur = 0;
    foreach (vecs[i]) begin
      while (cur < vecs[i].cyc) begin
        @(posedge clk);
        cur++;
      end
      @(negedge clk);
      check($sformatf("v%0d.x", i),       if_big.DrawX,       vecs[i].x);
      check($sformatf("v%0d.y", i),       if_big.DrawY,       vecs[i].y);
      check($sformatf("v%0d.hs", i),      if_big.hs,          vecs[i].hs);
      check($sformatf("v%0d.vs", i),      if_big.vs,          vecs[i].vs);
      check($sformatf("v%0d.blank", i),   if_big.blank,       vecs[i].blank);
      check($sformatf("v%0d.fs", i),      if_big.frame_start, vecs[i].fs);
      check($sformatf("v%0d.hs_d", i),    if_big.hs_d,        vecs[i].hs_d);
      check($sformatf("v%0d.blank_d", i), if_big.blank_d,     vecs[i].blank_d);
    end

    // whole third line (DrawY=2): sync width and visible width
    while (cur < 1599) begin
      @(posedge clk);
      cur++;
    end
    hs_low = 0;
    bl_cnt = 0;
    repeat (800) begin
      @(posedge clk);
      cur++;
      @(negedge clk);
      if (!if_big.hs) hs_low++;
      if (if_big.blank) bl_cnt++;
    end
    check("line.hs_low", hs_low, 96);
    check("line.blank",  bl_cnt, 640);
    check("line.y",      if_big.DrawY, 2);
    check("line.x_end",  if_big.DrawX, 799);

    // asynchronous reset mid-line
    while (cur < 2700) begin
      @(posedge clk);
      cur++;
    end
    @(negedge clk);
    check("pre.x",     if_big.DrawX, 300);
    check("pre.y",     if_big.DrawY, 3);
    check("pre.blank", if_big.blank, 1);
    #1 rst_big_n = 1'b0;
    #1;
    check("arst.x",       if_big.DrawX,       0);
    check("arst.y",       if_big.DrawY,       0);
    check("arst.hs",      if_big.hs,          1);
    check("arst.vs",      if_big.vs,          1);
    check("arst.blank",   if_big.blank,       0);
    check("arst.fs",      if_big.frame_start, 0);
    check("arst.blank_d", if_big.blank_d,     0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold.x",     if_big.DrawX, 0);
    check("hold.blank", if_big.blank, 0);
    rst_big_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel.x",     if_big.DrawX, 1);
    check("rel.y",     if_big.DrawY, 0);
    check("rel.blank", if_big.blank, 1);
    check("rel.hs",    if_big.hs,    1);

    // small instance: scoreboard runs every cycle from here on
    @(negedge clk);
    n_small     = 0;
    sb_run      = 1'b1;
    rst_small_n = 1'b1;

    last_pulse = 0;
    for (int k = 0; k < NPULSE; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!if_small.frame_start && gap < 3 * SF);
      check($sformatf("pulse%0d.seen", k), if_small.frame_start, 1);
      if (!if_small.frame_start) break;
      check($sformatf("pulse%0d.x", k), if_small.DrawX, 0);
      check($sformatf("pulse%0d.y", k), if_small.DrawY, 0);
      check($sformatf("pulse%0d.period", k), n_small - last_pulse, SF);
      last_pulse = n_small;
`ifdef VGA_FRAME_COUNT_EN
      @(negedge clk);
      check($sformatf("fc%0d", k), if_small.frame_count, 8'(k + 1));
`endif
    end

    // one full frame window
    vs_low = 0;
    bl_cnt = 0;
    fs_cnt = 0;
    repeat (SF) begin
      @(negedge clk);
      if (!if_small.vs) vs_low++;
      if (if_small.blank) bl_cnt++;
      if (if_small.frame_start) fs_cnt++;
    end
    check("frame.vs_low", vs_low, S_VS * SH);
    check("frame.blank",  bl_cnt, S_HV * S_VV);
    check("frame.fs",     fs_cnt, 1);

    // asynchronous reset inside the vertical sync, during horizontal sync
    guard = 0;
    while ((n_small % SF) != 5 * SH + 9 && guard < 2 * SF) begin
      @(negedge clk);
      guard++;
    end
    check("mid.reached", (n_small % SF), 5 * SH + 9);
    #1 sb_run = 1'b0;
    check("mid.pre_hs", if_small.hs, 0);
    check("mid.pre_vs", if_small.vs, 0);
    rst_small_n = 1'b0;
    #1;
    check("mid.x",    if_small.DrawX, 0);
    check("mid.y",    if_small.DrawY, 0);
    check("mid.hs",   if_small.hs,    1);
    check("mid.vs",   if_small.vs,    1);
    check("mid.vs_d", if_small.vs_d,  1);
`ifdef VGA_FRAME_COUNT_EN
    check("mid.fc",   if_small.frame_count, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_small     = 0;
    sb_run      = 1'b1;
    rst_small_n = 1'b1;
    repeat (2 * SF) @(negedge clk);
    sb_run = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
